// File: rtl/epoch_metrics.sv
// Per-sample binary cross-entropy cost and loss gradient for an output
// perceptron, plus per-epoch mean cost and thresholded accuracy reporting.
module epoch_metrics #(
  parameter int  samples_per_epoch = 4,
  parameter real threshold         = 0.5,
  parameter real epsilon           = 1.0e-7
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_valid,
  input  real  prediction,
  input  real  expected,
  input  logic flush,
  output real  sample_cost,
  output real  error_gradient,
  output real  epoch_cost,
  output int   epoch_correct,
  output int   epoch_count,
  output logic epoch_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state_reg, state_next;

  real  acc_cost_reg, acc_cost_next;
  int   acc_correct_reg, acc_correct_next;
  int   sample_idx_reg, sample_idx_next;
  real  sample_cost_reg, sample_cost_next;
  real  epoch_cost_reg, epoch_cost_next;
  int   epoch_correct_reg, epoch_correct_next;
  int   epoch_count_reg, epoch_count_next;
  logic epoch_done_reg, epoch_done_next;

  real  cost_now;
  real  gradient_now;
  logic hit;
  int   hit_inc;
  logic accept;
  logic closing;

  // Scoring of the sample currently on the inputs: cost, gradient, hit
  always_comb begin
    cost_now     = -(expected * $ln(prediction + epsilon)
                   + (1.0 - expected) * $ln(1.0 - prediction + epsilon));
    gradient_now = -(expected / (prediction + epsilon)
                   - (1.0 - expected) / (1.0 - prediction + epsilon));
    hit          = ((prediction < threshold) == (expected < threshold));
    hit_inc      = hit ? 1 : 0;
    accept       = sample_valid && !flush;
    closing      = (sample_idx_reg == samples_per_epoch - 1);
  end

  // Next-state: accumulate accepted samples, close epochs, honour flush
  always_comb begin
    state_next         = state_reg;
    acc_cost_next      = acc_cost_reg;
    acc_correct_next   = acc_correct_reg;
    sample_idx_next    = sample_idx_reg;
    sample_cost_next   = sample_cost_reg;
    epoch_cost_next    = epoch_cost_reg;
    epoch_correct_next = epoch_correct_reg;
    epoch_count_next   = epoch_count_reg;
    epoch_done_next    = 1'b0;

    if (flush) begin
      // Partial epoch is dropped; a simultaneous sample is ignored
      state_next       = IDLE;
      acc_cost_next    = 0.0;
      acc_correct_next = 0;
      sample_idx_next  = 0;
    end else if (accept) begin
      sample_cost_next = cost_now;
      if (closing) begin
        epoch_cost_next    = (acc_cost_reg + cost_now) / real'(samples_per_epoch);
        epoch_correct_next = acc_correct_reg + hit_inc;
        epoch_count_next   = epoch_count_reg + 1;
        epoch_done_next    = 1'b1;
        acc_cost_next      = 0.0;
        acc_correct_next   = 0;
        sample_idx_next    = 0;
        state_next         = IDLE;
      end else begin
        acc_cost_next    = acc_cost_reg + cost_now;
        acc_correct_next = acc_correct_reg + hit_inc;
        sample_idx_next  = sample_idx_reg + 1;
        state_next       = ACCUM;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      acc_cost_reg      <= 0.0;
      acc_correct_reg   <= 0;
      sample_idx_reg    <= 0;
      sample_cost_reg   <= 0.0;
      epoch_cost_reg    <= 0.0;
      epoch_correct_reg <= 0;
      epoch_count_reg   <= 0;
      epoch_done_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      acc_cost_reg      <= acc_cost_next;
      acc_correct_reg   <= acc_correct_next;
      sample_idx_reg    <= sample_idx_next;
      sample_cost_reg   <= sample_cost_next;
      epoch_cost_reg    <= epoch_cost_next;
      epoch_correct_reg <= epoch_correct_next;
      epoch_count_reg   <= epoch_count_next;
      epoch_done_reg    <= epoch_done_next;
    end
  end

  assign sample_cost    = sample_cost_reg;
  assign error_gradient = gradient_now;
  assign epoch_cost     = epoch_cost_reg;
  assign epoch_correct  = epoch_correct_reg;
  assign epoch_count    = epoch_count_reg;
  assign epoch_done     = epoch_done_reg;

endmodule

// File: tb/tb_epoch_metrics.sv
// Self-checking bench for epoch_metrics: table-driven vectors, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_epoch_metrics;

  localparam int  N   = 4;
  localparam real EPS = 1.0e-7;
  localparam real THR = 0.5;

  logic clk;
  logic rst;
  logic sample_valid;
  logic flush;
  real  prediction;
  real  expected;
  real  sample_cost;
  real  error_gradient;
  real  epoch_cost;
  int   epoch_correct;
  int   epoch_count;
  logic epoch_done;

  int tests;
  int fails;
  int txn;

  // Reference model state
  real m_costs[$];
  bit  m_hits[$];
  real m_sample_cost;
  real m_epoch_cost;
  int  m_epoch_correct;
  int  m_epoch_count;
  bit  m_done;

  epoch_metrics #(
    .samples_per_epoch(N),
    .threshold(THR),
    .epsilon(EPS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .prediction(prediction),
    .expected(expected),
    .flush(flush),
    .sample_cost(sample_cost),
    .error_gradient(error_gradient),
    .epoch_cost(epoch_cost),
    .epoch_correct(epoch_correct),
    .epoch_count(epoch_count),
    .epoch_done(epoch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real absr(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  function automatic real ref_cost(input real p, input real e);
    return -(e * $ln(p + EPS) + (1.0 - e) * $ln(1.0 - p + EPS));
  endfunction

  function automatic real ref_grad(input real p, input real e);
    return -(e / (p + EPS) - (1.0 - e) / (1.0 - p + EPS));
  endfunction

  task automatic chk_real(input string name, input real act, input real exp, input real tol);
    tests++;
    if (absr(act - exp) > tol) begin
      fails++;
      $display("[TB] FAIL %s: got %f, expected %f", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model of one clock edge, from the behavioural rules of the block
  task automatic model_edge(input bit r, input bit v, input bit f, input real p, input real e);
    real sum;
    int  hits;
    if (r) begin
      m_costs.delete();
      m_hits.delete();
      m_sample_cost = 0.0; m_epoch_cost = 0.0;
      m_epoch_correct = 0; m_epoch_count = 0; m_done = 0;
    end else if (f) begin
      m_costs.delete();
      m_hits.delete();
      m_done = 0;
    end else if (v) begin
      m_sample_cost = ref_cost(p, e);
      m_costs.push_back(m_sample_cost);
      m_hits.push_back((p < THR) == (e < THR));
      m_done = 0;
      if (m_costs.size() == N) begin
        sum = 0.0; hits = 0;
        foreach (m_costs[i]) sum += m_costs[i];
        foreach (m_hits[i]) hits += m_hits[i] ? 1 : 0;
        m_epoch_cost = sum / real'(N);
        m_epoch_correct = hits;
        m_epoch_count = m_epoch_count + 1;
        m_done = 1;
        m_costs.delete();
        m_hits.delete();
      end
    end else begin
      m_done = 0;
    end
  endtask

  // One transaction: drive, check gradient, clock, check registered outputs
  task automatic step(input bit r, input bit v, input bit f, input real p, input real e);
    real g;
    rst = r; sample_valid = v; flush = f; prediction = p; expected = e;
    #1;
    g = ref_grad(p, e);
    chk_real("error_gradient", error_gradient, g, 1.0e-6 * (1.0 + absr(g)));
    @(posedge clk);
    #1;
    model_edge(r, v, f, p, e);
    chk_real("sample_cost", sample_cost, m_sample_cost, 1.0e-9);
    chk_real("epoch_cost", epoch_cost, m_epoch_cost, 1.0e-9);
    chk_int("epoch_correct", epoch_correct, m_epoch_correct);
    chk_int("epoch_count", epoch_count, m_epoch_count);
    chk_int("epoch_done", int'(epoch_done), int'(m_done));
    txn++;
    $display("[TB] txn %0d rst=%0b v=%0b f=%0b p=%.3f e=%.1f cost=%.6f grad=%.4f ecost=%.6f ok=%0d cnt=%0d done=%0b",
             txn, r, v, f, p, e, sample_cost, error_gradient, epoch_cost,
             epoch_correct, epoch_count, epoch_done);
  endtask

  typedef struct {
    real p;
    real e;
    real cost;
    real grad;
    bit  done;
    real ecost;
    int  ecorrect;
    int  ecount;
  } vec_t;

  real and_p[4];
  real and_e[4];

  // AND-gate epoch, optionally with an idle cycle after each sample
  task automatic run_and(input bit gaps, output int dones);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, and_p[i], and_e[i]);
      if (epoch_done) dones++;
      if (gaps) begin
        step(0, 0, 0, 0.5, 0.0);
        if (epoch_done) dones++;
      end
    end
  endtask

  vec_t vecs[8];
  int   dones;
  bit   r, v, f;
  real  rp, re;

  initial begin
    tests = 0; fails = 0; txn = 0;
    and_p[0] = 0.1; and_p[1] = 0.2; and_p[2] = 0.3; and_p[3] = 0.9;
    and_e[0] = 0.0; and_e[1] = 0.0; and_e[2] = 0.0; and_e[3] = 1.0;

    vecs[0] = '{0.1,  0.0, 0.105361, 1.111111,  0, 0.0,       0, 0};
    vecs[1] = '{0.2,  0.0, 0.223144, 1.25,      0, 0.0,       0, 0};
    vecs[2] = '{0.3,  0.0, 0.356675, 1.428571,  0, 0.0,       0, 0};
    vecs[3] = '{0.9,  1.0, 0.105361, -1.111111, 1, 0.197635,  4, 1};
    vecs[4] = '{0.75, 1.0, 0.287682, -1.333333, 0, 0.197635,  4, 1};
    vecs[5] = '{0.25, 1.0, 1.386294, -4.0,      0, 0.197635,  4, 1};
    vecs[6] = '{0.6,  0.0, 0.916291, 2.5,       0, 0.197635,  4, 1};
    vecs[7] = '{0.5,  1.0, 0.693147, -2.0,      1, 0.8208535, 2, 2};

    // Reset, then idle with p=0.5 e=1
    step(1, 0, 0, 0.5, 1.0);
    step(1, 0, 0, 0.5, 1.0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0.5, 1.0);
      chk_real("idle_gradient", error_gradient, -2.0, 1.0e-6);
      chk_int("idle_done", int'(epoch_done), 0);
      chk_int("idle_count", epoch_count, 0);
      chk_real("idle_sample_cost", sample_cost, 0.0, 0.0);
    end

    // Single sample
    step(0, 1, 0, 0.5, 1.0);
    chk_real("single_cost", sample_cost, 0.693147, 1.0e-5);
    chk_int("single_done", int'(epoch_done), 0);
    chk_int("single_count", epoch_count, 0);
    step(0, 0, 1, 0.5, 1.0);

    // Table: two back-to-back epochs with hand-computed values
    for (int i = 0; i < 8; i++) begin
      rst = 0; sample_valid = 1; flush = 0;
      prediction = vecs[i].p; expected = vecs[i].e;
      #1;
      chk_real("vec_grad", error_gradient, vecs[i].grad, 1.0e-5);
      step(0, 1, 0, vecs[i].p, vecs[i].e);
      chk_real("vec_cost", sample_cost, vecs[i].cost, 1.0e-5);
      chk_int("vec_done", int'(epoch_done), int'(vecs[i].done));
      chk_real("vec_ecost", epoch_cost, vecs[i].ecost, 1.0e-5);
      chk_int("vec_ecorrect", epoch_correct, vecs[i].ecorrect);
      chk_int("vec_ecount", epoch_count, vecs[i].ecount);
    end
    step(0, 0, 0, 0.5, 0.0);
    chk_int("done_drop", int'(epoch_done), 0);

    // Threshold boundary epoch
    step(0, 1, 0, 0.5, 0.0);
    step(0, 1, 0, 0.49, 0.0);
    step(0, 1, 0, 0.6, 1.0);
    step(0, 1, 0, 0.4, 1.0);
    chk_int("thr_correct", epoch_correct, 2);
    chk_int("thr_done", int'(epoch_done), 1);

    // Flush mid-epoch, with a simultaneous valid
    step(1, 0, 0, 0.5, 0.0);
    step(0, 1, 0, 0.2, 0.0);
    step(0, 1, 0, 0.3, 0.0);
    step(0, 1, 1, 0.9, 1.0);
    chk_real("flush_hold_cost", sample_cost, 0.356675, 1.0e-5);
    chk_int("flush_done", int'(epoch_done), 0);
    run_and(0, dones);
    chk_int("flush_dones", dones, 1);
    chk_real("flush_ecost", epoch_cost, 0.197635, 1.0e-5);
    chk_int("flush_correct", epoch_correct, 4);
    chk_int("flush_count", epoch_count, 1);

    // Mid-epoch reset, then gapped AND epoch
    step(0, 1, 0, 0.1, 0.0);
    step(0, 1, 0, 0.2, 0.0);
    step(0, 1, 0, 0.3, 0.0);
    step(1, 1, 0, 0.9, 1.0);
    chk_real("rst_sample_cost", sample_cost, 0.0, 0.0);
    chk_real("rst_ecost", epoch_cost, 0.0, 0.0);
    chk_int("rst_count", epoch_count, 0);
    chk_int("rst_correct", epoch_correct, 0);
    run_and(1, dones);
    chk_int("gap_dones", dones, 1);
    chk_real("gap_ecost", epoch_cost, 0.197635, 1.0e-5);
    chk_int("gap_correct", epoch_correct, 4);
    chk_int("gap_count", epoch_count, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 99) < 75);
      f  = ($urandom_range(0, 99) < 5);
      rp = real'($urandom_range(1, 999)) / 1000.0;
      re = ($urandom_range(0, 1) == 1) ? 1.0 : 0.0;
      step(r, v, f, rp, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
